// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: core request/response and data-memory handshake bundle for the LSU.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit with lane steering, load extension, misalignment and timeout errors.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input logic       clk,
    input logic       srst,
    lsu_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t           r_state;
    logic             r_we;
    logic             r_uns;
    logic [1:0]       r_size;
    logic [1:0]       r_off;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mis;
    logic             w_exp;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_sh;
    logic [31:0]      w_ld;
    assign bus.req_ready = (r_state == IDLE);
    assign w_mis = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]);
    assign w_be = bus.req_size == 2'b00 ? 4'b0001 << bus.req_addr[1:0] :
                  bus.req_size == 2'b01 ? 4'b0011 << bus.req_addr[1:0] : 4'b1111;
    assign w_wdata = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}} :
                     bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    assign w_sh = bus.mem_rdata >> {r_off, 3'b000};
    assign w_ld = r_size == 2'b00 ? {{24{~r_uns & w_sh[7]}}, w_sh[7:0]} :
                  r_size == 2'b01 ? {{16{~r_uns & w_sh[15]}}, w_sh[15:0]} : w_sh;
    assign w_exp = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // A grant or rvalid in the expiry cycle takes priority over the timeout.
    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_uns         <= 1'b0;
            r_size        <= 2'b00;
            r_off         <= 2'b00;
            r_cnt         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 2'b00;
            bus.rsp_rdata <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_we   <= bus.req_we;
                    r_uns  <= bus.req_unsigned;
                    r_size <= bus.req_size;
                    r_off  <= bus.req_addr[1:0];
                    r_cnt  <= '0;
                    if (w_mis) begin
                        r_state       <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 2'b01;
                        bus.rsp_rdata <= '0;
                    end else begin
                        r_state       <= REQ;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.req_we;
                        bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                        bus.mem_be    <= w_be;
                        bus.mem_wdata <= w_wdata;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        r_state     <= r_we ? RESP : WAIT;
                        if (r_we) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 2'b00;
                            bus.rsp_rdata <= '0;
                        end
                    end else if (w_exp) begin
                        bus.mem_req   <= 1'b0;
                        r_state       <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 2'b10;
                        bus.rsp_rdata <= '0;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (bus.mem_rvalid || w_exp) begin
                        r_state       <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= bus.mem_rvalid ? 2'b00 : 2'b10;
                        bus.rsp_rdata <= bus.mem_rvalid ? w_ld : 32'd0;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit between the core datapath (ALU result = effective address, RD2 = store data) and a data memory with a request/grant/response handshake and variable latency. Handles byte/half/word sizing, byte-enable and write-data lane steering, and load sign/zero extension. Flags misaligned accesses and memory timeouts. Holds the core stalled (req_ready low) while an access is in flight.

Parameters:
TIMEOUT_CYCLES, 16, max cycles spent in REQ+WAIT before aborting with timeout error (>=2)
CNT_W, 5, width of timeout counter (must hold TIMEOUT_CYCLES-1)

Ports:
clk  input  1  clock, rising edge
srst  input  1  reset, asynchronous, active-low
req_valid  input  1  core access request
req_ready  output  1  LSU can accept request (IDLE only)
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  load zero-extend (LBU/LHU)
req_addr  input  32  byte address
req_wdata  input  32  store data (low bits used)
rsp_valid  output  1  one-cycle completion pulse
rsp_err  output  2  00 ok, 01 misaligned/illegal size, 10 timeout
rsp_rdata  output  32  extended load data (0 for stores/errors)
mem_req  output  1  memory request
mem_we  output  1  memory write
mem_addr  output  32  word address {req_addr[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_gnt  input  1  memory accepted request this cycle
mem_rvalid  input  1  load data valid
mem_rdata  input  32  raw load word

Behaviour:
- States: IDLE, REQ, WAIT, RESP. All state, counter and registered outputs async-cleared on srst=0.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=00, rsp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, counter=0.
- req_ready = (state==IDLE). Request accepted when req_valid & req_ready; all req_* fields captured into registers that cycle.
- Misalignment check at acceptance: size 01 & addr[0]=1; size 10 & addr[1:0]!=0; size 11 always. If misaligned -> RESP with rsp_err=01, no memory access.
- Aligned accept -> REQ. In REQ: mem_req=1; mem_we, mem_addr, mem_be, mem_wdata driven from captured registers and held stable until grant.
- mem_be: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111. Loads drive the same mem_be.
- mem_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- REQ & mem_gnt: store -> RESP (rsp_err=00); load -> WAIT. mem_req deasserts the cycle after gnt.
- mem_rvalid is only valid at least one cycle after gnt; rvalid seen in IDLE, REQ or RESP is ignored.
- WAIT & mem_rvalid: extract lane (byte = rdata>>(8*addr[1:0]) bits 7:0; half = rdata>>(8*addr[1:0]) bits 15:0), sign-extend unless req_unsigned, register into rsp_rdata -> RESP.
- Timeout: counter clears on entry to REQ and counts every cycle in REQ/WAIT. If it reaches TIMEOUT_CYCLES-1 with no gnt (REQ) or rvalid (WAIT), go to RESP with rsp_err=10 and rsp_rdata=0; mem_req drops. A gnt/rvalid arriving in the same cycle as expiry wins; there is no error.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_err/rsp_rdata hold until the next RESP.
- Latency, zero-wait memory: store accept at cycle 0, gnt at cycle 1, rsp_valid at cycle 2. Load: gnt at cycle 1, rvalid at cycle 2, rsp_valid at cycle 3. Misaligned: rsp_valid at cycle 1.
- Reset mid-access: immediate IDLE, mem_req=0; late rvalid/gnt after reset ignored.
- Back-to-back: next request can be accepted the cycle after RESP (in IDLE).

Test Plan:
- Store byte: addr=0x1003, wdata=0xAB, gnt immediate -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB; rsp_valid at cycle 2, rsp_err=00.
- Load byte signed/unsigned: addr=0x2001, mem_rdata=0x1234F6AA -> signed rsp_rdata=0xFFFFFFF6; unsigned rsp_rdata=0x000000F6; rsp_valid at cycle 3.
- Load half addr=0x2002, rdata=0x8001xxxx, 3-cycle gnt delay -> mem_req/addr/be=1100 held stable until gnt; rsp_rdata=0xFFFF8001.
- Misaligned word addr=0x3002 and size=11 -> no mem_req ever; rsp_valid at cycle 1 with rsp_err=01.
- Timeout: gnt never asserted, TIMEOUT_CYCLES=16 -> mem_req high 16 cycles, then rsp_err=10, rsp_rdata=0; repeat with rvalid exactly on expiry cycle -> rsp_err=00.
- srst pulsed low while in WAIT -> all outputs at reset values, req_ready=1; stray rvalid afterwards produces no rsp_valid.
